// File: rtl/stage_if_fetch.sv
// Instruction-fetch stage: assembles 32-bit instructions from four little-endian byte reads.
// Optional macro IF_PERF_CNT_EN adds perf_fetch_o / perf_abort_o event counters.
module stage_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  stall,
    input  logic        br_flag,
    input  logic [31:0] br_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [7:0]  mem_data,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        stall_req_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_abort_o
`endif
);

    typedef enum logic [1:0] {FETCH, READY, ABORT} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_pc;
    logic [31:0] w_nextPc;
    logic [1:0]  r_byteCnt;
    logic [1:0]  w_nextCnt;
    logic [23:0] r_instBuf;
    logic [31:0] r_abortAddr;
    logic [31:0] r_pcOut;
    logic [31:0] r_instOut;
    logic [31:0] w_fetchAddr;
    logic        w_storeByte;
    logic        w_complete;
    logic        w_branchTaken;
    logic        w_unusedStall;

    assign w_unusedStall = ^stall[5:1];
    assign w_fetchAddr   = r_pc + {30'b0, r_byteCnt};

    // ABORT keeps presenting the abandoned address until the arbiter answers it.
    assign mem_req     = !reset && (r_state != READY);
    assign mem_addr    = (r_state == ABORT) ? r_abortAddr : w_fetchAddr;
    assign stall_req_o = reset || (r_state != READY);
    assign pc_o        = r_pcOut;
    assign inst_o      = r_instOut;

    always_comb begin
        w_nextState   = r_state;
        w_nextPc      = r_pc;
        w_nextCnt     = r_byteCnt;
        w_storeByte   = 1'b0;
        w_complete    = 1'b0;
        w_branchTaken = 1'b0;
        case (r_state)
            FETCH: begin
                if (br_flag) begin
                    w_nextPc      = br_target;
                    w_nextCnt     = 2'd0;
                    w_branchTaken = 1'b1;
                    w_nextState   = mem_valid ? FETCH : ABORT;
                end else if (mem_valid) begin
                    if (r_byteCnt == 2'd3) begin
                        w_complete  = 1'b1;
                        w_nextCnt   = 2'd0;
                        w_nextState = READY;
                    end else begin
                        w_storeByte = 1'b1;
                        w_nextCnt   = r_byteCnt + 2'd1;
                    end
                end
            end
            READY: begin
                if (br_flag) begin
                    w_nextPc    = br_target;
                    w_nextCnt   = 2'd0;
                    w_nextState = FETCH;
                end else if (!stall[0]) begin
                    w_nextPc    = r_pc + 32'd4;
                    w_nextState = FETCH;
                end
            end
            ABORT: begin
                if (br_flag) begin
                    w_nextPc      = br_target;
                    w_branchTaken = 1'b1;
                end
                if (mem_valid) begin
                    w_nextCnt   = 2'd0;
                    w_nextState = FETCH;
                end
            end
            default: w_nextState = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_byteCnt   <= 2'd0;
            r_instBuf   <= 24'd0;
            r_abortAddr <= 32'd0;
            r_pcOut     <= 32'd0;
            r_instOut   <= 32'd0;
        end else begin
            r_state   <= w_nextState;
            r_pc      <= w_nextPc;
            r_byteCnt <= w_nextCnt;
            if (w_storeByte) begin
                case (r_byteCnt)
                    2'd0:    r_instBuf[7:0]   <= mem_data;
                    2'd1:    r_instBuf[15:8]  <= mem_data;
                    default: r_instBuf[23:16] <= mem_data;
                endcase
            end
            if (w_complete) begin
                r_pcOut   <= r_pc;
                r_instOut <= {mem_data, r_instBuf};
            end
            if (r_state == FETCH && w_nextState == ABORT) begin
                r_abortAddr <= w_fetchAddr;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perfFetch;
    logic [31:0] r_perfAbort;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perfFetch <= 32'd0;
            r_perfAbort <= 32'd0;
        end else begin
            if (w_complete)    r_perfFetch <= r_perfFetch + 32'd1;
            if (w_branchTaken) r_perfAbort <= r_perfAbort + 32'd1;
        end
    end

    assign perf_fetch_o = r_perfFetch;
    assign perf_abort_o = r_perfAbort;
`endif

endmodule

// File: tb/tb_stage_if_fetch.sv
// Self-checking bench for stage_if_fetch: directed scenarios followed by randomized traffic
// compared against a behavioural fetch model that answers from a byte-addressed memory image.
module tb_stage_if_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  stall;
    logic        br_flag;
    logic [31:0] br_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [7:0]  mem_data;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        stall_req_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_abort_o;
`endif

    int testCount = 0;
    int failCount = 0;

    logic [7:0] memImg [0:255];

    // Behavioural model: mode 0 = fetching, 1 = instruction ready, 2 = waiting out an abandoned read
    bit          mReset;
    int          mMode;
    int          mCnt;
    logic [31:0] mPc;
    logic [31:0] mAbortAddr;
    logic [31:0] mPcOut;
    logic [31:0] mInstOut;
    logic [31:0] mFetchCnt;
    logic [31:0] mAbortCnt;

    always #5 clock = ~clock;

    stage_if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .br_flag     (br_flag),
        .br_target   (br_target),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data),
        .pc_o        (pc_o),
        .inst_o      (inst_o),
        .stall_req_o (stall_req_o)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_o(perf_fetch_o),
        .perf_abort_o(perf_abort_o)
`endif
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] t;
        w = 32'd0;
        for (int i = 0; i < 4; i++) begin
            t = a + 32'(i);
            w = w | (32'(memImg[t[7:0]]) << (8 * i));
        end
        return w;
    endfunction

    function automatic logic [31:0] expAddr();
        return (mMode == 2) ? mAbortAddr : (mPc + 32'(mCnt));
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mMode     = 0;
        mCnt      = 0;
        mPc       = 32'h0000_0000;
        mAbortAddr = 32'd0;
        mPcOut    = 32'd0;
        mInstOut  = 32'd0;
        mFetchCnt = 32'd0;
        mAbortCnt = 32'd0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic modelEdge();
        logic [31:0] addrNow;
        addrNow = expAddr();
        if (mReset) begin
            modelReset();
        end else if (mMode == 0) begin
            if (br_flag) begin
                mAbortCnt++;
                mPc  = br_target;
                mCnt = 0;
                if (!mem_valid) begin
                    mAbortAddr = addrNow;
                    mMode = 2;
                end
            end else if (mem_valid) begin
                if (mCnt == 3) begin
                    mPcOut   = mPc;
                    mInstOut = memWord(mPc);
                    mFetchCnt++;
                    mCnt  = 0;
                    mMode = 1;
                end else begin
                    mCnt++;
                end
            end
        end else if (mMode == 1) begin
            if (br_flag) begin
                mPc   = br_target;
                mCnt  = 0;
                mMode = 0;
            end else if (!stall[0]) begin
                mPc   = mPc + 32'd4;
                mMode = 0;
            end
        end else begin
            if (br_flag) begin
                mAbortCnt++;
                mPc = br_target;
            end
            if (mem_valid) begin
                mCnt  = 0;
                mMode = 0;
            end
        end
    endtask

    task automatic checkOutput();
        logic expReq;
        expReq = !mReset && (mMode != 1);
        check1("mem_req", mem_req, expReq);
        if (expReq) check32("mem_addr", mem_addr, expAddr());
        check1("stall_req_o", stall_req_o, mReset || (mMode != 1));
        check32("pc_o", pc_o, mPcOut);
        check32("inst_o", inst_o, mInstOut);
`ifdef IF_PERF_CNT_EN
        check32("perf_fetch_o", perf_fetch_o, mFetchCnt);
        check32("perf_abort_o", perf_abort_o, mAbortCnt);
`endif
    endtask

    // Drive one cycle from the falling edge, check pre-edge outputs, then step model and DUT.
    task automatic applyStimulus(input bit rst, input bit s0, input bit br,
                                 input logic [31:0] tgt, input bit mv);
        logic [31:0] a;
        reset     = rst;
        stall     = {5'($urandom), s0};
        br_flag   = br;
        br_target = tgt;
        mem_valid = mv;
        mReset    = rst;
        a         = expAddr();
        mem_data  = mv ? memImg[a[7:0]] : 8'($urandom);
        #1;
        checkOutput();
        modelEdge();
        @(posedge clock);
        @(negedge clock);
    endtask

    logic [31:0] wrapAddr [4];

    initial begin
        bit          rs;
        bit          s0;
        bit          br;
        bit          mv;
        logic [31:0] tgt;

        for (int i = 0; i < 256; i++) memImg[i] = 8'($urandom);
        memImg[0] = 8'h13;
        memImg[1] = 8'h00;
        memImg[2] = 8'h00;
        memImg[3] = 8'h00;
        wrapAddr[0] = 32'hFFFF_FFFE;
        wrapAddr[1] = 32'hFFFF_FFFF;
        wrapAddr[2] = 32'h0000_0000;
        wrapAddr[3] = 32'h0000_0001;

        reset = 1'b1; stall = 6'd0; br_flag = 1'b0; br_target = 32'd0;
        mem_valid = 1'b0; mem_data = 8'd0; mReset = 1'b1;
        modelReset();
        @(posedge clock);
        @(negedge clock);

        applyStimulus(1, 0, 0, 32'd0, 0);
        applyStimulus(1, 0, 0, 32'd0, 0);

        // First instruction, one byte per cycle
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 32'd0, 1);
        check32("first_pc", pc_o, 32'h0000_0000);
        check32("first_inst", inst_o, 32'h0000_0013);
        check1("first_ready", stall_req_o, 1'b0);

        // Hold READY with stall[0], then release
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 32'd0, 0);
        check32("stall_inst_held", inst_o, 32'h0000_0013);
        applyStimulus(0, 0, 0, 32'd0, 0);
        check1("release_req", mem_req, 1'b1);
        check32("release_addr", mem_addr, 32'h0000_0004);

        // Slow arbiter: each byte answered on the fourth cycle
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 32'd0, (i % 4) == 3);
            if (i == 14) check1("slow_not_ready", stall_req_o, 1'b1);
        end
        check1("slow_ready", stall_req_o, 1'b0);
        check32("slow_pc", pc_o, 32'h0000_0004);

        // Branch with byte outstanding goes through ABORT
        applyStimulus(0, 0, 0, 32'd0, 0);
        applyStimulus(0, 0, 1, 32'h0000_0100, 0);
        applyStimulus(0, 0, 0, 32'd0, 0);
        check32("abort_old_addr", mem_addr, 32'h0000_0008);
        applyStimulus(0, 0, 0, 32'd0, 0);
        applyStimulus(0, 0, 0, 32'd0, 1);
        check32("abort_new_addr", mem_addr, 32'h0000_0100);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 32'd0, 1);
        check32("abort_pc", pc_o, 32'h0000_0100);

        // Branch coincident with the fourth byte
        applyStimulus(0, 0, 0, 32'd0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 32'd0, 1);
        applyStimulus(0, 0, 1, 32'h0000_0200, 1);
        check1("br4_no_ready", stall_req_o, 1'b1);
        check32("br4_pc_held", pc_o, 32'h0000_0100);
        check32("br4_addr", mem_addr, 32'h0000_0200);

        // Fetch across the top of the address space
        applyStimulus(0, 0, 1, 32'hFFFF_FFFE, 1);
        for (int i = 0; i < 4; i++) begin
            check32("wrap_addr", mem_addr, wrapAddr[i]);
            applyStimulus(0, 0, 0, 32'd0, 1);
        end
        check32("wrap_pc", pc_o, 32'hFFFF_FFFE);
        applyStimulus(0, 0, 0, 32'd0, 0);
        check32("wrap_next_addr", mem_addr, 32'h0000_0002);
`ifdef IF_PERF_CNT_EN
        check32("perf_fetch_dir", perf_fetch_o, 32'd4);
        check32("perf_abort_dir", perf_abort_o, 32'd3);
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rs  = ($urandom_range(99) == 0);
            s0  = ($urandom_range(2) == 0);
            br  = ($urandom_range(9) == 0);
            tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(3)))
                                           : 32'($urandom);
            mv  = (!rs && mMode != 1) ? ($urandom_range(1) == 1) : 1'b0;
            applyStimulus(rs, s0, br, tgt, mv);
        end
        #1;
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
